// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: word width, canonical encodings and fetch FSM states.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP   = 32'h00000013;
  localparam logic [XLEN-1:0] INSTR_ECALL = 32'h00000073;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    ERR  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: holds one fetched pc/instruction pair behind a valid/ready handshake.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            kill,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
);

  logic            vld_p1;
  logic [XLEN-1:0] pc_p1;
  logic [XLEN-1:0] instr_p1;

  // ---- stage p1: IF/ID output register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      pc_p1    <= '0;
      instr_p1 <= INSTR_NOP;
    end else if (load) begin
      vld_p1   <= 1'b1;
      pc_p1    <= pc_in;
      instr_p1 <= instr_in;
    end else if (kill || (vld_p1 && out_ready)) begin
      vld_p1   <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_pc    = pc_p1;
  assign out_instr = instr_p1;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives imem and feeds decode through the IF/ID register.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          IMEM_WORDS = 64
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic            halted,
  output logic            fetch_err,
  output logic [XLEN-1:0] fetch_count
);

  localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

  fetch_state_e    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [XLEN-1:0] count_next;
  logic            pc_legal, fire, kill;

  function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign pc_legal = (pc[1:0] == 2'b00) && (pc[31:2] < IMEM_LIMIT);
  assign fire     = (state == RUN) && !redirect_valid && pc_legal && (!out_valid || out_ready);

  always_comb begin
    state_next = state;
    pc_next    = pc;
    count_next = fetch_count;
    kill       = 1'b0;
    if (state == RUN) begin
      if (redirect_valid) begin
        // Wrong-path kill wins over a same-cycle handshake.
        pc_next = redirect_pc;
        kill    = 1'b1;
      end else if (!pc_legal) begin
        // pc is left at the faulting address for debug.
        state_next = ERR;
        kill       = 1'b1;
      end else if (fire) begin
        pc_next    = pc + 32'd4;
        count_next = sat_inc(fetch_count);
        if (imem_rdata == INSTR_ECALL) state_next = HALT;
      end
    end
  end

  // ---- stage p0: PC, FSM and counter ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      fetch_count <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      fetch_count <= count_next;
    end
  end

  assign imem_addr = pc;
  assign halted    = (state == HALT);
  assign fetch_err = (state == ERR);

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (fire),
    .kill      (kill),
    .pc_in     (pc),
    .instr_in  (imem_rdata),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr)
  );

endmodule
